// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single data-memory port between the LSQ load
// path and the committed-store drain path, one transaction outstanding.
// Optional feature: define DMEM_ARB_RR_EN for round-robin arbitration instead
// of fixed store priority with load aging.
module dmem_port_arbiter #(
  parameter int unsigned TAG_W        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  // Load path
  input  logic             ld_req_i,
  input  logic [31:0]      ld_addr_i,
  input  logic [TAG_W-1:0] ld_tag_i,
  output logic             ld_gnt_o,
  output logic             ld_resp_valid_o,
  output logic [31:0]      ld_resp_data_o,
  output logic [TAG_W-1:0] ld_resp_tag_o,
  // Store drain path
  input  logic             st_req_i,
  input  logic [31:0]      st_addr_i,
  input  logic [31:0]      st_data_i,
  output logic             st_gnt_o,
  output logic             st_done_o,
  // Pipeline flush
  input  logic             flush_i,
  // Memory port
  output logic             dmem_read_o,
  output logic             dmem_write_o,
  output logic [31:0]      dmem_addr_o,
  output logic [31:0]      dmem_data_o,
  input  logic [31:0]      dmem_rd_data_i,
  input  logic             dmem_done_i
);

  typedef enum logic [1:0] {StIdle, StLdBusy, StStBusy} state_e;

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [TAG_W-1:0] tag_q, tag_d;
  logic             kill_q, kill_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
  logic             st_done_q, st_done_d;

  logic             ld_elig;
  logic             ld_win;
  logic             st_win;
  logic             is_idle;

  // A flushed load may not be granted; stores never see the flush.
  assign ld_elig = ld_req_i & ~flush_i;
  assign is_idle = (state_q == StIdle) & reset_n_i;

`ifdef DMEM_ARB_RR_EN
  // 1 when the store path took the most recent grant.
  logic rr_last_st_q, rr_last_st_d;

  // Contended: the side that did not win last time goes first.
  always_comb begin
    ld_win = ld_elig & (~st_req_i | rr_last_st_q);
  end

  // Pointer follows whichever side was granted.
  always_comb begin
    rr_last_st_d = rr_last_st_q;
    if (ld_gnt_o) begin
      rr_last_st_d = 1'b0;
    end else if (st_gnt_o) begin
      rr_last_st_d = 1'b1;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      rr_last_st_q <= 1'b0;
    end else begin
      rr_last_st_q <= rr_last_st_d;
    end
  end
`else
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);

  logic [CntW-1:0] starve_q, starve_d;
  logic            starved;

  assign starved = (starve_q == CntW'(STARVE_LIMIT));

  // Stores win unless the load has been held off long enough.
  always_comb begin
    ld_win = ld_elig & (~st_req_i | starved);
  end

  // Age a waiting load, saturating; any grant or dropped request restarts it.
  always_comb begin
    starve_d = starve_q;
    if (!ld_req_i || ld_gnt_o) begin
      starve_d = '0;
    end else if (!starved) begin
      starve_d = starve_q + CntW'(1);
    end
  end

  // Starvation counter register.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end
`endif

  assign st_win   = st_req_i & ~ld_win;
  assign ld_gnt_o = is_idle & ld_win;
  assign st_gnt_o = is_idle & st_win;

  // Next-state: capture on grant, hold the bus until done, register responses.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    data_d       = data_q;
    tag_d        = tag_q;
    kill_d       = kill_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_tag_d   = resp_tag_q;
    st_done_d    = 1'b0;
    unique case (state_q)
      StIdle: begin
        kill_d = 1'b0;
        if (ld_gnt_o) begin
          state_d = StLdBusy;
          addr_d  = {ld_addr_i[31:2], 2'b00};
          tag_d   = ld_tag_i;
        end else if (st_gnt_o) begin
          state_d = StStBusy;
          addr_d  = {st_addr_i[31:2], 2'b00};
          data_d  = st_data_i;
        end
      end
      StLdBusy: begin
        if (flush_i) begin
          kill_d = 1'b1;
        end
        if (dmem_done_i) begin
          state_d = StIdle;
          kill_d  = 1'b0;
          // The read still completes on the bus; only the response is dropped.
          if (!kill_q && !flush_i) begin
            resp_valid_d = 1'b1;
            resp_data_d  = dmem_rd_data_i;
            resp_tag_d   = tag_q;
          end
        end
      end
      StStBusy: begin
        if (dmem_done_i) begin
          state_d   = StIdle;
          st_done_d = 1'b1;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset abandons any in-flight transaction.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      data_q       <= '0;
      tag_q        <= '0;
      kill_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_tag_q   <= '0;
      st_done_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      tag_q        <= tag_d;
      kill_q       <= kill_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_tag_q   <= resp_tag_d;
      st_done_q    <= st_done_d;
    end
  end

  assign dmem_read_o     = (state_q == StLdBusy);
  assign dmem_write_o    = (state_q == StStBusy);
  assign dmem_addr_o     = addr_q;
  assign dmem_data_o     = data_q;
  assign ld_resp_valid_o = resp_valid_q;
  assign ld_resp_data_o  = resp_data_q;
  assign ld_resp_tag_o   = resp_tag_q;
  assign st_done_o       = st_done_q;

endmodule
